spike_decoder: RTL
==================

Name: spike_decoder

Overview:
Receive-side counterpart to the LIF neuron. It takes a single-bit spike train and decodes it back into three magnitude estimates:
- a windowed spike rate
- the inter-spike interval (ISI)
- a leaky post-synaptic trace, which approximates the input current that drove the neuron

It sits downstream of the neuron's spike output in the top-level wrapper, and its outputs drive the board-visible pins.

Parameters:
WINDOW_LOG2, 4, rate window length is 2^WINDOW_LOG2 enabled cycles; legal range 2..12.
LEAK_SHIFT, 3, trace leak per cycle is trace>>LEAK_SHIFT; legal range 1..7.
WEIGHT, 32, 8-bit amount added to the trace per spike.
BURST_TH, 8, burst asserted when rate_out >= BURST_TH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  sample enable; when 0, all state is frozen
spike_in  input  1  spike train, one spike per high cycle
rate_out  output  8  spike count of last completed window, saturating at 255
rate_valid  output  1  one-cycle pulse when rate_out updates
isi_out  output  8  enabled cycles between the last two spikes, saturating at 255
isi_valid  output  1  one-cycle pulse when isi_out updates
trace_out  output  8  leaky integrated spike trace
burst  output  1  registered (rate_out >= BURST_TH)

Behaviour:
- Decided interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - all outputs 0
  - win_cnt = 0, spike_cnt = 0, isi_cnt = 0, trace = 0
  - FSM state = WAIT_FIRST
- Reset takes priority over en. Reset mid-window discards the partial count, and the next window starts at slot 0.
- en = 0 behaviour:
  - no counter, FSM or trace update
  - rate_valid and isi_valid forced to 0 that cycle
  - rate_out, isi_out, trace_out and burst hold their values
- A spike is counted only when en = 1 and spike_in = 1.
- Rate window:
  - win_cnt increments each enabled cycle and wraps at 2^WINDOW_LOG2 - 1 -> 0.
  - On the edge that ends slot 2^WINDOW_LOG2 - 1:
    - rate_out <= min(spike_cnt + current spike, 255)
    - rate_valid <= 1
    - spike_cnt <= 0
    - burst <= (that new value >= BURST_TH)
  - On other enabled edges: spike_cnt += spike, and rate_valid <= 0.
  - spike_cnt is WINDOW_LOG2+1 bits wide internally; rate_out saturates when that exceeds 8 bits.
- ISI FSM:
  - WAIT_FIRST: on the first spike, go to TRACK and set isi_cnt <= 1. No isi_valid.
  - TRACK, on a spike: isi_out <= isi_cnt, isi_valid <= 1, isi_cnt <= 1.
  - TRACK, no spike: isi_cnt <= min(isi_cnt + 1, 255), isi_valid <= 0.
  - Spikes on back-to-back enabled cycles give isi_out = 1.
  - isi_out = 255 means ">= 255".
- Trace, every enabled cycle:
  - t9 = trace - (trace >> LEAK_SHIFT) + (spike ? WEIGHT : 0), computed in 9 bits
  - trace <= (t9 > 255) ? 255 : t9
  - trace_out = trace (registered)
  - Leak never underflows. A nonzero trace decays toward the fixed point where trace>>LEAK_SHIFT = 0, i.e. trace < 2^LEAK_SHIFT, and stays there without spikes.
- Latency:
  - rate_out, isi_out and trace_out are visible the cycle after the triggering edge's inputs are sampled.
  - All outputs are registered; no combinational input-to-output paths.
- Simultaneous events: a spike on the window's final slot counts in the closing window, updates the ISI and adds to the trace, all on the same edge.

Test Plan:
- Reset, then en = 1 with no spikes for 32 cycles -> rate_valid pulses after cycle 16 and cycle 32 with rate_out = 0; isi_valid never asserts; trace_out = 0; burst = 0.
- Spike every 4th enabled cycle, defaults -> every window gives rate_out = 4; every isi_valid after the first spike gives isi_out = 4; burst = 0.
- spike_in held high for 16 cycles -> rate_out = 16 and burst = 1; isi_out = 1 on each pulse; trace climbs 32, 60, 85, ... and saturates at 255.
- Single spike from zero trace -> trace_out sequence 32, 28, 25, 22, 20, 18 ...; the trace decays to 7 and holds there (7>>3 = 0).
- Two spikes 300 enabled cycles apart -> isi_out = 255 with one isi_valid pulse; toggling en = 0 for 10 cycles mid-gap does not change the count.
- Assert rst for 1 cycle mid-window after 5 spikes -> all outputs 0 next cycle; the next window reports only spikes after reset; the FSM is back in WAIT_FIRST, so the first post-reset spike gives no isi_valid.

Source files
------------

// File: rtl/spike_decoder_if.sv
// Bundle between a spike source and the spike decoder: sample/spike inputs
// and the three decoded magnitude estimates.
interface spike_if;
    logic       en;
    logic       spike_in;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic [7:0] isi_out;
    logic       isi_valid;
    logic [7:0] trace_out;
    logic       burst;

    modport master (output en, spike_in,
                    input  rate_out, rate_valid, isi_out, isi_valid, trace_out, burst);
    modport slave  (input  en, spike_in,
                    output rate_out, rate_valid, isi_out, isi_valid, trace_out, burst);
endinterface

// File: rtl/spike_decoder.sv
// Decodes a single-bit spike train into windowed rate, inter-spike interval
// and a leaky post-synaptic trace. All outputs are registered.
module spike_decoder #(
    parameter int WINDOW_LOG2 = 4,
    parameter int LEAK_SHIFT  = 3,
    parameter int WEIGHT      = 32,
    parameter int BURST_TH    = 8
) (
    input  logic    clk,
    input  logic    rst,
    spike_if.slave  bus
);
    typedef enum logic {WAIT_FIRST, TRACK} state_t;

    localparam logic [7:0]  WEIGHT8 = 8'(WEIGHT);
    localparam logic [12:0] BURST13 = 13'(BURST_TH);

    state_t                 state, state_d;
    logic [WINDOW_LOG2-1:0] win_cnt, win_cnt_d;
    logic [WINDOW_LOG2:0]   spike_cnt, spike_cnt_d;
    logic [7:0]             isi_cnt, isi_cnt_d;
    logic [7:0]             rate, rate_d, isi, isi_d, trace, trace_d;
    logic                   rate_vld, rate_vld_d, isi_vld, isi_vld_d, burst, burst_d;
    logic                   spk;
    logic [12:0]            sum;
    logic [8:0]             t9;

    assign spk = bus.en & bus.spike_in;

    always_comb begin
        state_d     = state;
        win_cnt_d   = win_cnt;
        spike_cnt_d = spike_cnt;
        isi_cnt_d   = isi_cnt;
        rate_d      = rate;
        isi_d       = isi;
        trace_d     = trace;
        burst_d     = burst;
        rate_vld_d  = 1'b0;
        isi_vld_d   = 1'b0;
        // Window count including this cycle's spike; 13 bits covers the largest window.
        sum = 13'(spike_cnt) + 13'(spk);
        // Leak is at most the trace itself, so the 9-bit sum never wraps below zero.
        t9  = 9'(trace) - 9'(trace >> LEAK_SHIFT) + (spk ? 9'(WEIGHT8) : 9'd0);

        if (bus.en) begin
            win_cnt_d = win_cnt + 1'b1;
            if (&win_cnt) begin
                rate_d      = (sum > 13'd255) ? 8'hff : sum[7:0];
                rate_vld_d  = 1'b1;
                spike_cnt_d = '0;
                burst_d     = ({5'd0, rate_d} >= BURST13);
            end else begin
                spike_cnt_d = sum[WINDOW_LOG2:0];
            end

            trace_d = t9[8] ? 8'hff : t9[7:0];

            case (state)
                WAIT_FIRST: begin
                    if (spk) begin
                        state_d   = TRACK;
                        isi_cnt_d = 8'd1;
                    end
                end
                TRACK: begin
                    if (spk) begin
                        isi_d     = isi_cnt;
                        isi_vld_d = 1'b1;
                        isi_cnt_d = 8'd1;
                    end else if (isi_cnt != 8'hff) begin
                        isi_cnt_d = isi_cnt + 8'd1;
                    end
                end
                default: state_d = WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_FIRST;
            win_cnt   <= '0;
            spike_cnt <= '0;
            isi_cnt   <= '0;
            rate      <= '0;
            isi       <= '0;
            trace     <= '0;
            burst     <= 1'b0;
            rate_vld  <= 1'b0;
            isi_vld   <= 1'b0;
        end else begin
            state     <= state_d;
            win_cnt   <= win_cnt_d;
            spike_cnt <= spike_cnt_d;
            isi_cnt   <= isi_cnt_d;
            rate      <= rate_d;
            isi       <= isi_d;
            trace     <= trace_d;
            burst     <= burst_d;
            rate_vld  <= rate_vld_d;
            isi_vld   <= isi_vld_d;
        end
    end

    assign bus.rate_out   = rate;
    assign bus.rate_valid = rate_vld;
    assign bus.isi_out    = isi;
    assign bus.isi_valid  = isi_vld;
    assign bus.trace_out  = trace;
    assign bus.burst      = burst;
endmodule
